coeff_replay_fifo: RTL and testbench
====================================

Name: coeff_replay_fifo

Overview:
Parametrised successor to the coefficient FIFO. It buffers DATA_W-bit floating-point coefficients for the approximation engine and detects the START_TOKEN control word on the write side. Read-side replay rewinds to the start of the unreleased coefficient window, so the engine can re-run a polynomial without the producer rewriting. The window is freed explicitly by the consumer. It sits between the host/DMA coefficient loader and the NLA evaluation FSM.

Parameters:
DATA_W, 32, coefficient width in bits
ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W entries
START_TOKEN, 32'h7F900000, control word (NaN pattern) that is never stored and pulses start_o

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
wr_en_i  in  1  write request
data_i  in  DATA_W  write data
rd_en_i  in  1  read request
redo_i  in  1  rewind read pointer to window base
release_i  in  1  free all entries already read (base <= rd_ptr)
data_o  out  DATA_W  read data, registered
rd_valid_o  out  1  data_o updated this cycle
start_o  out  1  one-cycle pulse: START_TOKEN accepted
full_o  out  1  occupancy == DEPTH
empty_o  out  1  no unread entries (rd_ptr == wr_ptr)
level_o  out  ADDR_W+1  unread entries (wr_ptr - rd_ptr)
occupancy_o  out  ADDR_W+1  held entries (wr_ptr - base_ptr)
overflow_o  out  1  sticky: write dropped while full
underflow_o  out  1  sticky: read requested while empty

Behaviour:
- Pointers wr_ptr, rd_ptr, base_ptr are ADDR_W+1 bits. The low ADDR_W bits address storage, and the MSB is the wrap bit. All arithmetic is modulo 2**(ADDR_W+1).
- Invariant: base_ptr <= rd_ptr <= wr_ptr in modular distance. occupancy <= DEPTH.
- Reset (rst_i=1 at an edge): all pointers 0, data_o=0, rd_valid_o=0, start_o=0, overflow_o=0, underflow_o=0. Therefore empty_o=1, full_o=0, level_o=0, occupancy_o=0. Storage contents are not cleared. Reset mid-operation discards all entries and any in-flight read.
- Write: a write is accepted when wr_en_i=1, full_o=0 and data_i != START_TOKEN. It stores at wr_ptr and increments wr_ptr.
- Token write: wr_en_i=1 with data_i == START_TOKEN. Nothing is stored, wr_ptr is unchanged, and start_o=1 on the next cycle. The token is accepted even when the FIFO is full.
- Write while full (non-token): the write is dropped and overflow_o is set. State is otherwise unchanged.
- Read: a read is accepted when rd_en_i=1, empty_o=0 and redo_i=0. On the next cycle, data_o = mem[rd_ptr] and rd_valid_o=1, and rd_ptr increments. Read latency is 1 cycle.
- Read while empty: underflow_o is set, rd_valid_o=0 next cycle, and data_o holds its value.
- Any cycle without an accepted read leaves rd_valid_o=0 next cycle and data_o held.
- Simultaneous write and read in the same cycle are both accepted. The flags use pre-edge state. A read of an empty FIFO in the same cycle as a write returns nothing (no bypass).
- Full FIFO with a same-cycle read: the write is still dropped. Reading does not free space; only release_i frees space.
- redo_i=1: rd_ptr <= base_ptr next cycle. Any same-cycle rd_en_i is ignored and is not counted as underflow. Writes are unaffected.
- release_i=1: base_ptr <= rd_ptr (pre-edge value, so a same-cycle read is not freed). Release has priority over redo; a simultaneous redo_i is ignored.
- Flags and levels (empty_o, full_o, level_o, occupancy_o) are combinational from the registered pointers.
- Sticky overflow_o and underflow_o clear only on reset.

Optional Feature:
COEFF_FIFO_ALMOST_FLAGS_EN
- Defined: adds parameter ALMOST_FULL_TH (default DEPTH-2) and outputs almost_full_o and almost_empty_o.
  - almost_full_o = occupancy_o >= ALMOST_FULL_TH.
  - almost_empty_o = level_o <= 1.
  - Both are combinational and read 0/1 respectively after reset.
- Undefined: these ports and the parameter do not exist. Core behaviour is identical.

Decomposition:
- Package coeff_fifo_pkg:
  - default START_TOKEN constant
  - default DATA_W and ADDR_W constants
  - ptr_t typedef helper (ADDR_W+1 bits)
- Sub-module coeff_sdp_ram: simple dual-port RAM, one write port and one registered read port, DATA_W x DEPTH, inferable as BRAM or distributed RAM.
- Top level holds the pointers, flag logic, token detect and sticky errors.

Test Plan:
- Reset, write 3 values A,B,C, read 3 -> data_o A,B,C each 1 cycle after rd_en_i. rd_valid_o pulses 3 times; then empty_o=1, level_o=0, occupancy_o=3.
- After the above, pulse redo_i, read 3 -> A,B,C again. Then pulse release_i -> occupancy_o=0, full_o=0.
- Write 16 values (ADDR_W=4) -> full_o=1. A 17th write is dropped and sets overflow_o. Read all 16 -> full_o stays 1 until release_i, then full_o=0.
- Write START_TOKEN between B and C -> start_o pulses one cycle after. Reads return only A,B,C. level_o=3.
- Wrap: fill 16, read and release 10, write 10 more -> correct FIFO order across the wrap, full_o=1 at occupancy 16.
- rd_en_i on empty -> underflow_o=1 sticky, no rd_valid_o. Reset mid-stream with level_o=5 -> all flags and levels return to reset values.

Source files
------------

// File: rtl/coeff_fifo_pkg.sv
// ----------------------------------------------------------------------------
// coeff_fifo_pkg
// Shared constants and types for the coefficient replay FIFO.
//   DEF_DATA_W      : default coefficient width
//   DEF_ADDR_W      : default log2 depth
//   DEF_START_TOKEN : NaN pattern used as the in-band start control word
//   ptr_t           : pointer type for the default configuration (wrap bit + address)
// ----------------------------------------------------------------------------
package coeff_fifo_pkg;

    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_ADDR_W      = 4;
    localparam logic [31:0] DEF_START_TOKEN = 32'h7F90_0000;

    // One extra MSB distinguishes "full" from "empty" when addresses match.
    typedef logic [DEF_ADDR_W:0] ptr_t;

endpackage : coeff_fifo_pkg

// File: rtl/coeff_sdp_ram.sv
// ----------------------------------------------------------------------------
// coeff_sdp_ram
// Simple dual-port RAM, DATA_W x 2**ADDR_W, one write port, one registered
// read port. Maps onto block RAM or distributed RAM with output register.
//   clk   : clock
//   rst   : synchronous active-high reset of the read register only
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata updates on the next edge, otherwise holds
//   raddr : read address
//   rdata : registered read data
// ----------------------------------------------------------------------------
module coeff_sdp_ram
    import coeff_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: storage has no reset so it can map onto RAM primitives; only the
    // output register is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : coeff_sdp_ram

// File: rtl/coeff_replay_fifo.sv
// ----------------------------------------------------------------------------
// coeff_replay_fifo
// Coefficient FIFO with in-band START_TOKEN detection and read-side replay.
// Entries stay held between base_ptr and wr_ptr until the consumer releases
// them, so redo_i can rewind the read pointer and re-stream the window.
//
// Optional feature macro: COEFF_FIFO_ALMOST_FLAGS_EN
//   adds parameter ALMOST_FULL_TH and outputs almost_full_o / almost_empty_o.
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   wr_en_i, data_i   : write request / data (START_TOKEN is never stored)
//   rd_en_i           : read request, data_o valid one cycle later
//   redo_i            : rewind rd_ptr to base_ptr
//   release_i         : free everything already read (base_ptr <= rd_ptr)
//   data_o, rd_valid_o: registered read data and its valid pulse
//   start_o           : one-cycle pulse after START_TOKEN is seen
//   full_o, empty_o   : held entries == DEPTH / no unread entries
//   level_o           : unread entries (wr_ptr - rd_ptr)
//   occupancy_o       : held entries (wr_ptr - base_ptr)
//   overflow_o        : sticky, non-token write dropped while full
//   underflow_o       : sticky, read requested while empty
//   almost_full_o     : occupancy_o >= ALMOST_FULL_TH (optional)
//   almost_empty_o    : level_o <= 1 (optional)
// ----------------------------------------------------------------------------
module coeff_replay_fifo
    import coeff_fifo_pkg::*;
#(
    parameter int unsigned        DATA_W      = DEF_DATA_W,
    parameter int unsigned        ADDR_W      = DEF_ADDR_W,
    parameter logic [DATA_W-1:0]  START_TOKEN = DATA_W'(DEF_START_TOKEN)
`ifdef COEFF_FIFO_ALMOST_FLAGS_EN
    ,
    parameter int unsigned        ALMOST_FULL_TH = (2**ADDR_W) - 2
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_en_i,
    input  logic              redo_i,
    input  logic              release_i,
    output logic [DATA_W-1:0] data_o,
    output logic              rd_valid_o,
    output logic              start_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic [ADDR_W:0]   occupancy_o,
    output logic              overflow_o,
    output logic              underflow_o
`ifdef COEFF_FIFO_ALMOST_FLAGS_EN
    ,
    output logic              almost_full_o,
    output logic              almost_empty_o
`endif
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    typedef logic [ADDR_W:0] fifo_ptr_t;

    fifo_ptr_t wr_ptr;
    fifo_ptr_t rd_ptr;
    fifo_ptr_t base_ptr;

    logic is_token;
    logic wr_fire;
    logic rd_fire;

    // Flags come straight from the registered pointers; modular subtraction
    // keeps distances correct across the wrap.
    assign level_o     = wr_ptr - rd_ptr;
    assign occupancy_o = wr_ptr - base_ptr;
    assign empty_o     = (wr_ptr == rd_ptr);
    assign full_o      = (occupancy_o == fifo_ptr_t'(DEPTH));

`ifdef COEFF_FIFO_ALMOST_FLAGS_EN
    assign almost_full_o  = (32'(occupancy_o) >= ALMOST_FULL_TH);
    assign almost_empty_o = (level_o <= fifo_ptr_t'(1));
`endif

    // The token is consumed regardless of fullness and never touches storage.
    assign is_token = wr_en_i && (data_i == START_TOKEN);
    assign wr_fire  = wr_en_i && !is_token && !full_o;
    // A pending rewind suppresses the read entirely, even if release wins.
    assign rd_fire  = rd_en_i && !empty_o && !redo_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what the same-cycle rules rely on.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            base_ptr    <= '0;
            rd_valid_o  <= 1'b0;
            start_o     <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_fire;
            start_o    <= is_token;

            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (release_i) begin
                // Pre-edge rd_ptr: a read issued this cycle stays held.
                base_ptr <= rd_ptr;
                if (rd_fire) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end else if (redo_i) begin
                rd_ptr <= base_ptr;
            end else if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (wr_en_i && !is_token && full_o) begin
                overflow_o <= 1'b1;
            end
            if (rd_en_i && empty_o && !redo_i) begin
                underflow_o <= 1'b1;
            end
        end
    end

    coeff_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (wr_fire),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (data_i),
        .re    (rd_fire),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (data_o)
    );

endmodule : coeff_replay_fifo

// File: tb/tb_coeff_replay_fifo.sv
// ----------------------------------------------------------------------------
// tb_coeff_replay_fifo
// Directed bench for coeff_replay_fifo (DATA_W=32, ADDR_W=4).
// ----------------------------------------------------------------------------
module tb_coeff_replay_fifo;

    localparam logic [31:0] TOK = 32'h7F90_0000;
    localparam logic [31:0] VA  = 32'h3F80_0000;
    localparam logic [31:0] VB  = 32'h4000_0000;
    localparam logic [31:0] VC  = 32'h4040_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        rd_en_i = 1'b0;
    logic        redo_i = 1'b0;
    logic        release_i = 1'b0;
    logic [31:0] data_o;
    logic        rd_valid_o;
    logic        start_o;
    logic        full_o;
    logic        empty_o;
    logic [4:0]  level_o;
    logic [4:0]  occupancy_o;
    logic        overflow_o;
    logic        underflow_o;
`ifdef COEFF_FIFO_ALMOST_FLAGS_EN
    logic        almost_full_o;
    logic        almost_empty_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    coeff_replay_fifo #(
        .DATA_W (32),
        .ADDR_W (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .data_i      (data_i),
        .rd_en_i     (rd_en_i),
        .redo_i      (redo_i),
        .release_i   (release_i),
        .data_o      (data_o),
        .rd_valid_o  (rd_valid_o),
        .start_o     (start_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .level_o     (level_o),
        .occupancy_o (occupancy_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
`ifdef COEFF_FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 time unit later,
    // then return all request lines to idle.
    task automatic cyc(input logic w, input logic [31:0] d, input logic r,
                       input logic rd, input logic rl);
        wr_en_i   = w;
        data_i    = d;
        rd_en_i   = r;
        redo_i    = rd;
        release_i = rl;
        @(posedge clk);
        #1;
        wr_en_i   = 1'b0;
        rd_en_i   = 1'b0;
        redo_i    = 1'b0;
        release_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd_expect(input string tag, input logic [31:0] exp);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
        check({tag, "_data"}, data_o, exp);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"},  32'(empty_o), 32'd1);
        check({tag, "_full"},   32'(full_o), 32'd0);
        check({tag, "_level"},  32'(level_o), 32'd0);
        check({tag, "_occ"},    32'(occupancy_o), 32'd0);
        check({tag, "_rdv"},    32'(rd_valid_o), 32'd0);
        check({tag, "_start"},  32'(start_o), 32'd0);
        check({tag, "_ovf"},    32'(overflow_o), 32'd0);
        check({tag, "_unf"},    32'(underflow_o), 32'd0);
        check({tag, "_data"},   data_o, 32'd0);
`ifdef COEFF_FIFO_ALMOST_FLAGS_EN
        check({tag, "_afull"},  32'(almost_full_o), 32'd0);
        check({tag, "_aempty"}, 32'(almost_empty_o), 32'd1);
`endif
    endtask

    initial begin
        @(negedge clk);

        // Reset state
        do_reset();
        check_reset_state("rst");

        // Basic write / read
        wr(VA); wr(VB); wr(VC);
        check("wr3_level", 32'(level_o), 32'd3);
        check("wr3_occ", 32'(occupancy_o), 32'd3);
        rd_expect("rdA", VA);
        rd_expect("rdB", VB);
        rd_expect("rdC", VC);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("idle_rdv", 32'(rd_valid_o), 32'd0);
        check("idle_hold", data_o, VC);
        check("rd3_empty", 32'(empty_o), 32'd1);
        check("rd3_level", 32'(level_o), 32'd0);
        check("rd3_occ", 32'(occupancy_o), 32'd3);

        // Replay, with a same-cycle read that must be ignored
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("redo_rdv", 32'(rd_valid_o), 32'd0);
        check("redo_unf", 32'(underflow_o), 32'd0);
        check("redo_level", 32'(level_o), 32'd3);
        rd_expect("rrA", VA);
        rd_expect("rrB", VB);
        rd_expect("rrC", VC);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rel_occ", 32'(occupancy_o), 32'd0);
        check("rel_full", 32'(full_o), 32'd0);

        // Fill, overflow, drain; full persists until release
        for (int i = 0; i < 16; i++) wr(32'h1000 + i);
        check("fill_full", 32'(full_o), 32'd1);
        check("fill_level", 32'(level_o), 32'd16);
        check("fill_ovf0", 32'(overflow_o), 32'd0);
        wr(32'hDEAD_BEEF);
        check("ovf_set", 32'(overflow_o), 32'd1);
        check("ovf_level", 32'(level_o), 32'd16);
        for (int i = 0; i < 16; i++) rd_expect($sformatf("drain%0d", i), 32'h1000 + i);
        check("drain_empty", 32'(empty_o), 32'd1);
        check("drain_full", 32'(full_o), 32'd1);
        wr(32'h0BAD_0BAD);
        check("drain_wr_dropped", 32'(level_o), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("drain_rel_full", 32'(full_o), 32'd0);
        check("drain_rel_occ", 32'(occupancy_o), 32'd0);

        // Start token between B and C
        wr(VA); wr(VB);
        check("pre_tok_start", 32'(start_o), 32'd0);
        wr(TOK);
        check("tok_start", 32'(start_o), 32'd1);
        check("tok_level", 32'(level_o), 32'd2);
        wr(VC);
        check("tok_start_clr", 32'(start_o), 32'd0);
        check("tok_level3", 32'(level_o), 32'd3);
        rd_expect("tokA", VA);
        rd_expect("tokB", VB);
        rd_expect("tokC", VC);
        check("tok_empty", 32'(empty_o), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Wrap across the storage boundary
        for (int i = 0; i < 16; i++) wr(32'h2000 + i);
        check("wrap_full1", 32'(full_o), 32'd1);
        wr(TOK);
        check("wrap_tok_full", 32'(start_o), 32'd1);
        for (int i = 0; i < 10; i++) rd_expect($sformatf("wrapA%0d", i), 32'h2000 + i);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("wrap_rel_occ", 32'(occupancy_o), 32'd6);
        check("wrap_rel_full", 32'(full_o), 32'd0);
        for (int i = 0; i < 10; i++) wr(32'h3000 + i);
        check("wrap_full2", 32'(full_o), 32'd1);
        check("wrap_occ16", 32'(occupancy_o), 32'd16);
        check("wrap_level16", 32'(level_o), 32'd16);
        for (int i = 10; i < 16; i++) rd_expect($sformatf("wrapB%0d", i), 32'h2000 + i);
        for (int i = 0; i < 10; i++) rd_expect($sformatf("wrapC%0d", i), 32'h3000 + i);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("wrap_done_occ", 32'(occupancy_o), 32'd0);

        // Underflow, sticky, data held
        check("unf_pre", 32'(underflow_o), 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("unf_set", 32'(underflow_o), 32'd1);
        check("unf_rdv", 32'(rd_valid_o), 32'd0);
        check("unf_hold", data_o, 32'h3009);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("unf_sticky", 32'(underflow_o), 32'd1);

        // Write + read on empty in one cycle: no bypass
        cyc(1'b1, 32'h5555_0001, 1'b1, 1'b0, 1'b0);
        check("nobyp_rdv", 32'(rd_valid_o), 32'd0);
        check("nobyp_level", 32'(level_o), 32'd1);
        rd_expect("nobyp_rd", 32'h5555_0001);

        // Release with a same-cycle read keeps the read entry held
        wr(32'h6000); wr(32'h6001);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("relrd_data", data_o, 32'h6000);
        check("relrd_occ", 32'(occupancy_o), 32'd2);
        check("relrd_level", 32'(level_o), 32'd1);
        // Release beats redo
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("relredo_occ", 32'(occupancy_o), 32'd1);
        check("relredo_level", 32'(level_o), 32'd1);
        rd_expect("relredo_rd", 32'h6001);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Reset mid-stream with level 5 and sticky flags set
        for (int i = 0; i < 5; i++) wr(32'h7000 + i);
        check("mid_level5", 32'(level_o), 32'd5);
        rd_en_i = 1'b1;
        do_reset();
        check_reset_state("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_coeff_replay_fifo
